// File: rtl/spare_coverage_checker.sv
// spare_coverage_checker
// Sequential validity check for one candidate BIRA repair solution. A solution
// is latched on start, the DSSS/RLSS popcounts are checked, then each pivot is
// visited in index order and every must pivot greedily claims the lowest-index
// free spare that the programmable coverage map allows for its bank and type.

module spare_coverage_checker #(
  parameter int N_PIVOT     = 8,
  parameter int N_SPARE     = 8,
  parameter int N_RLSS      = 4,
  parameter int N_BANK      = 2,
  parameter int BNK_W       = 2,
  parameter int DSSS_ONES   = 4,
  parameter int RLSS_ONES   = 2,
  parameter bit EARLY_ABORT = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_SPARE-1:0]          dsss,
  input  logic [N_RLSS-1:0]           rlss,
  input  logic [N_PIVOT-1:0]          pivot_en,
  input  logic [N_PIVOT*BNK_W-1:0]    p_bnk,
  input  logic [N_PIVOT*3-1:0]        must_flag,
  input  logic [N_BANK*3*N_SPARE-1:0] spare_map,
  output logic                        busy,
  output logic                        done,
  output logic [N_SPARE-1:0]          unused_spare,
  output logic [N_PIVOT-1:0]          uncover_must_pivot,
  output logic                        signal_valid
);

  localparam int DW    = $clog2(N_SPARE + 1);
  localparam int RW    = $clog2(N_RLSS + 1);
  localparam int IDX_W = (N_PIVOT > 1) ? $clog2(N_PIVOT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state, state_n;

  logic [N_SPARE-1:0]          dsss_q;
  logic [N_RLSS-1:0]           rlss_q;
  logic [N_PIVOT-1:0]          pivot_en_q;
  logic [N_PIVOT*BNK_W-1:0]    p_bnk_q;
  logic [N_PIVOT*3-1:0]        must_flag_q;
  logic [N_BANK*3*N_SPARE-1:0] spare_map_q;
  logic [IDX_W-1:0]            idx, idx_n;

  logic                        load;
  logic                        busy_n, done_n, valid_n;
  logic [N_SPARE-1:0]          unused_n;
  logic [N_PIVOT-1:0]          uncover_n;

  logic [2:0]                  cur_flag;
  logic [BNK_W-1:0]            cur_bank;
  logic [1:0]                  cur_type;
  logic                        one_hot, bank_ok, active, hit, miss;
  logic [N_SPARE-1:0]          map_sel, avail, low_bit;
  logic                        counts_ok;

  function automatic logic [DW-1:0] pop_spare(input logic [N_SPARE-1:0] v);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < N_SPARE; i++) s = s + DW'(v[i]);
    return s;
  endfunction

  function automatic logic [RW-1:0] pop_rlss(input logic [N_RLSS-1:0] v);
    logic [RW-1:0] s;
    s = '0;
    for (int i = 0; i < N_RLSS; i++) s = s + RW'(v[i]);
    return s;
  endfunction

  // Decode the pivot under inspection and find the spare it would claim.
  always_comb begin
    cur_flag = must_flag_q[int'(idx)*3 +: 3];
    cur_bank = p_bnk_q[int'(idx)*BNK_W +: BNK_W];
    cur_type = 2'd0;
    one_hot  = 1'b1;
    case (cur_flag)
      3'b100:  cur_type = 2'd0;
      3'b010:  cur_type = 2'd1;
      3'b001:  cur_type = 2'd2;
      default: one_hot  = 1'b0;
    endcase
    map_sel = '0;
    bank_ok = 1'b0;
    for (int b = 0; b < N_BANK; b++) begin
      if (int'(cur_bank) == b) begin
        bank_ok = 1'b1;
        for (int t = 0; t < 3; t++) begin
          if (int'(cur_type) == t) map_sel = spare_map_q[(b*3+t)*N_SPARE +: N_SPARE];
        end
      end
    end
    avail     = unused_spare & map_sel;
    low_bit   = avail & (~avail + N_SPARE'(1));
    active    = pivot_en_q[idx] && (cur_flag != 3'b000);
    hit       = active && one_hot && bank_ok && (avail != '0);
    miss      = active && !hit;
    counts_ok = (pop_spare(dsss_q) == DW'(DSSS_ONES)) && (pop_rlss(rlss_q) == RW'(RLSS_ONES));
  end

  // Next-state and next-result logic; results hold unless a state acts on them.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    busy_n    = busy;
    done_n    = 1'b0;
    valid_n   = signal_valid;
    unused_n  = unused_spare;
    uncover_n = uncover_must_pivot;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          unused_n  = dsss;
          uncover_n = '0;
          valid_n   = 1'b1;
          busy_n    = 1'b1;
          state_n   = COUNT;
        end
      end
      COUNT: begin
        if (!counts_ok) begin
          valid_n = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          idx_n   = '0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (hit) unused_n = unused_spare & ~low_bit;
        if (miss) begin
          uncover_n[idx] = 1'b1;
          valid_n        = 1'b0;
        end
        if ((idx == IDX_W'(N_PIVOT - 1)) || (EARLY_ABORT && miss)) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State, result and latched-operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      idx                <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      signal_valid       <= 1'b0;
      unused_spare       <= '1;
      uncover_must_pivot <= '0;
      dsss_q             <= '0;
      rlss_q             <= '0;
      pivot_en_q         <= '0;
      p_bnk_q            <= '0;
      must_flag_q        <= '0;
      spare_map_q        <= '0;
    end else begin
      state              <= state_n;
      idx                <= idx_n;
      busy               <= busy_n;
      done               <= done_n;
      signal_valid       <= valid_n;
      unused_spare       <= unused_n;
      uncover_must_pivot <= uncover_n;
      if (load) begin
        dsss_q      <= dsss;
        rlss_q      <= rlss;
        pivot_en_q  <= pivot_en;
        p_bnk_q     <= p_bnk;
        must_flag_q <= must_flag;
        spare_map_q <= spare_map;
      end
    end
  end

endmodule
